// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed common-anode 7-segment scanner with per-frame digit
// snapshot, programmable inter-digit blanking and leading-zero suppression.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_en,
  input  logic       lzb,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       snap3_q, snap3_d;
  logic [3:0]       snap2_q, snap2_d;
  logic [3:0]       snap1_q, snap1_d;
  logic [3:0]       snap0_q, snap0_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic             snap_lzb_q, snap_lzb_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             wrap;
  logic             snap_edge;
  logic             blank;
  logic [3:0]       cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Pin levels are computed from the current state and registered, so the
  // pins lag (idx, cnt, snapshot) by one cycle.
  always_comb begin
    wrap          = (cnt_q == CNT_LAST);
    cnt_d         = wrap ? '0 : cnt_q + 1'b1;
    idx_d         = wrap ? idx_q + 2'd1 : idx_q;
    snap_edge     = wrap && (idx_q == 2'd3);
    frame_start_d = snap_edge;

    snap3_d    = snap_edge ? digit3 : snap3_q;
    snap2_d    = snap_edge ? digit2 : snap2_q;
    snap1_d    = snap_edge ? digit1 : snap1_q;
    snap0_d    = snap_edge ? digit0 : snap0_q;
    snap_dp_d  = snap_edge ? dp_en  : snap_dp_q;
    snap_lzb_d = snap_edge ? lzb    : snap_lzb_q;

    case (idx_q)
      2'd0:    cur_digit = snap0_q;
      2'd1:    cur_digit = snap1_q;
      2'd2:    cur_digit = snap2_q;
      default: cur_digit = snap3_q;
    endcase

    // A suppressed leading zero keeps slot 3 at blank levels for the whole slot.
    blank = (cnt_q < BLANK_END) ||
            ((idx_q == 2'd3) && snap_lzb_q && (snap3_q == 4'd0));

    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'b1111111 : decode(cur_digit);
    dp_d  = blank ? 1'b1 : ~snap_dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      snap3_q       <= 4'd0;
      snap2_q       <= 4'd0;
      snap1_q       <= 4'd0;
      snap0_q       <= 4'd0;
      snap_dp_q     <= 4'd0;
      snap_lzb_q    <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap3_q       <= snap3_d;
      snap2_q       <= snap2_d;
      snap1_q       <= snap1_d;
      snap0_q       <= snap0_d;
      snap_dp_q     <= snap_dp_d;
      snap_lzb_q    <= snap_lzb_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with REFRESH_DIV=8,
// BLANK_CYCLES=2 (32-cycle frames, 2 blank + 6 lit cycles per slot).
module tb_seven_seg_scanner;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * RDIV;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic       clk;
  logic       rst;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [3:0] dp_en;
  logic       lzb;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int vectors;
  int miscompares;

  seven_seg_scanner #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .dp_en      (dp_en),
    .lzb        (lzb),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Caller sits on the negedge where frame_start is high (k=0); pins at k
  // reflect state cycle k-1, so slot = (k-1)/RDIV and cnt = (k-1)%RDIV.
  task automatic check_frame(input string name,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpm, input logic blank3,
                             input int poke_k, input logic [3:0] poke_val);
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp;
    logic       fs_exp;
    logic       blk;
    int         s;
    int         c;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      s = (k - 1) / RDIV;
      c = (k - 1) % RDIV;
      blk = (c < BLANK) || (s == 3 && blank3);
      an_exp = blk ? 4'b1111 : ~(4'b0001 << s);
      case (s)
        0:       seg_exp = s0;
        1:       seg_exp = s1;
        2:       seg_exp = s2;
        default: seg_exp = s3;
      endcase
      if (blk) seg_exp = 7'b1111111;
      dp_exp = blk ? 1'b1 : ~dpm[s];
      fs_exp = (k == FRAME);
      vectors += 4;
      if (an !== an_exp) begin
        miscompares++;
        $display("[TB] FAIL %s an k=%0d got %b expected %b", name, k, an, an_exp);
      end
      if (seg !== seg_exp) begin
        miscompares++;
        $display("[TB] FAIL %s seg k=%0d got %b expected %b", name, k, seg, seg_exp);
      end
      if (dp !== dp_exp) begin
        miscompares++;
        $display("[TB] FAIL %s dp k=%0d got %b expected %b", name, k, dp, dp_exp);
      end
      if (frame_start !== fs_exp) begin
        miscompares++;
        $display("[TB] FAIL %s frame_start k=%0d got %b expected %b", name, k, frame_start, fs_exp);
      end
      if (k == poke_k) digit0 = poke_val;
    end
  endtask

  // Advances to the next frame_start pulse, bounded to just over one frame.
  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 4 && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s wait_frame got no frame_start expected pulse within %0d cycles", name, FRAME + 4);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    digit3 = 4'($urandom_range(0, 15));
    digit2 = 4'($urandom_range(0, 15));
    digit1 = 4'($urandom_range(0, 15));
    digit0 = 4'($urandom_range(0, 15));
    dp_en  = 4'($urandom_range(0, 15));
    lzb    = 1'($urandom_range(0, 1));
    repeat (3) begin
      @(negedge clk);
      vectors += 4;
      if (an !== 4'b1111) begin
        miscompares++;
        $display("[TB] FAIL reset an got %b expected 1111", an);
      end
      if (seg !== 7'b1111111) begin
        miscompares++;
        $display("[TB] FAIL reset seg got %b expected 1111111", seg);
      end
      if (dp !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset dp got %b expected 1", dp);
      end
      if (frame_start !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset frame_start got %b expected 0", frame_start);
      end
    end
    digit3 = 4'd9;
    digit2 = 4'd5;
    digit1 = 4'd9;
    digit0 = 4'd9;
    dp_en  = 4'b0100;
    lzb    = 1'b0;
    rst    = 1'b0;
    check_frame("first_frame", SEG_0, SEG_0, SEG_0, SEG_0, 4'b0000, 1'b0, -1, 4'd0);
  endtask

  task automatic test_steady();
    check_frame("steady", SEG_9, SEG_9, SEG_5, SEG_9, 4'b0100, 1'b0, -1, 4'd0);
  endtask

  task automatic test_blanking();
    int blank_cnt [4];
    int lit_cnt [4];
    int s;
    for (int i = 0; i < 4; i++) begin
      blank_cnt[i] = 0;
      lit_cnt[i]   = 0;
    end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      s = (k - 1) / RDIV;
      if (an === 4'b1111) blank_cnt[s]++;
      else if (an === ~(4'b0001 << s)) lit_cnt[s]++;
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("[TB] FAIL blanking multi_anode k=%0d got an=%b expected at most one low", k, an);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors += 2;
      if (blank_cnt[i] != BLANK) begin
        miscompares++;
        $display("[TB] FAIL blanking blank_len slot=%0d got %0d expected %0d", i, blank_cnt[i], BLANK);
      end
      if (lit_cnt[i] != RDIV - BLANK) begin
        miscompares++;
        $display("[TB] FAIL blanking lit_len slot=%0d got %0d expected %0d", i, lit_cnt[i], RDIV - BLANK);
      end
    end
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL blanking frame_start got %b expected 1", frame_start);
    end
  endtask

  task automatic test_tear_free();
    digit0 = 4'd3;
    wait_frame("tear_free");
    // digit0 flips to 7 while slot 1 is being scanned (state idx=1, cnt=4).
    check_frame("tear_free_old", SEG_3, SEG_9, SEG_5, SEG_9, 4'b0100, 1'b0, 12, 4'd7);
    check_frame("tear_free_new", SEG_7, SEG_9, SEG_5, SEG_9, 4'b0100, 1'b0, -1, 4'd0);
  endtask

  task automatic test_lzb();
    digit3 = 4'd0;
    lzb    = 1'b1;
    wait_frame("lzb_on");
    check_frame("lzb_on", SEG_7, SEG_9, SEG_5, SEG_0, 4'b0100, 1'b1, -1, 4'd0);
    lzb = 1'b0;
    wait_frame("lzb_off");
    check_frame("lzb_off", SEG_7, SEG_9, SEG_5, SEG_0, 4'b0100, 1'b0, -1, 4'd0);
  endtask

  task automatic test_out_of_range();
    digit1 = 4'hC;
    wait_frame("out_of_range");
    check_frame("out_of_range", SEG_7, SEG_DASH, SEG_5, SEG_0, 4'b0100, 1'b0, -1, 4'd0);
  endtask

  task automatic test_midslot_reset();
    // From a frame_start negedge, 21 more cycles puts the state at idx=2, cnt=5.
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (an !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL midslot_reset an got %b expected 1111", an);
    end
    if (seg !== 7'b1111111) begin
      miscompares++;
      $display("[TB] FAIL midslot_reset seg got %b expected 1111111", seg);
    end
    if (dp !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midslot_reset dp got %b expected 1", dp);
    end
    if (frame_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midslot_reset frame_start got %b expected 0", frame_start);
    end
    rst = 1'b0;
    check_frame("after_reset", SEG_0, SEG_0, SEG_0, SEG_0, 4'b0000, 1'b0, -1, 4'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_steady();
    test_blanking();
    test_tear_free();
    test_lzb();
    test_out_of_range();
    test_midslot_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
